bcd_pulse_burst: RTL and testbench

- Stimulus transmitter for the vibration pulse-counting path.
- Takes a 4-digit packed-BCD count and emits exactly that many clean, fixed-width pulses on pulse_out.
- pulse_out drives the `up` input of the BCD event counter for board bring-up and loop-back self-test.
- A downstream counter reset at the same time reads back exactly the loaded value.

---
 rtl/bcd_pulse_burst.sv | 146 ++++++++++++++
 tb/tb_bcd_pulse_burst.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_pulse_burst.sv
// Stimulus transmitter: loads a 4-digit packed-BCD count and emits exactly that
// many fixed-width pulses on pulse_out, with registered busy/done/remaining/err status.
module bcd_pulse_burst #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 4,
    parameter int CW       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] count_in,
    output logic        pulse_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] remaining,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYC - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] timer, timer_nxt;
    logic          pulse_nxt, busy_nxt, done_nxt, err_nxt;
    logic [15:0]   remaining_nxt;
    logic          count_valid;

    // Ripple BCD decrement: a zero digit wraps to 9 and borrows from the next digit.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign count_valid = (count_in[3:0]   <= 4'd9) && (count_in[7:4]   <= 4'd9) &&
                         (count_in[11:8]  <= 4'd9) && (count_in[15:12] <= 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= 16'h0000;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            pulse_out <= pulse_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Every output is computed here one cycle ahead, then registered above.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        pulse_nxt     = pulse_out;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        err_nxt       = err;
        remaining_nxt = remaining;

        case (state)
            IDLE: begin
                if (start) begin
                    if (!count_valid) begin
                        err_nxt = 1'b1;
                    end else if (count_in == 16'h0000) begin
                        err_nxt       = 1'b0;
                        remaining_nxt = 16'h0000;
                        done_nxt      = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        err_nxt       = 1'b0;
                        remaining_nxt = count_in;
                        pulse_nxt     = 1'b1;
                        busy_nxt      = 1'b1;
                        timer_nxt     = HIGH_LOAD;
                        state_nxt     = HIGH;
                    end
                end
            end

            HIGH: begin
                if (timer == '0) begin
                    pulse_nxt     = 1'b0;
                    remaining_nxt = bcd_dec(remaining);
                    timer_nxt     = LOW_LOAD;
                    state_nxt     = LOW;
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end

            // The low gap also follows the last pulse, so done lands after it.
            LOW: begin
                if (timer == '0) begin
                    if (remaining != 16'h0000) begin
                        pulse_nxt = 1'b1;
                        timer_nxt = HIGH_LOAD;
                        state_nxt = HIGH;
                    end else begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_pulse_burst.sv
// Self-checking bench for bcd_pulse_burst: directed and randomized bursts checked
// cycle by cycle against an arithmetic model of the pulse train.
module tb_bcd_pulse_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [15:0] count_in, count2;
    logic        pulse_a, busy_a, done_a, err_a;
    logic [15:0] rem_a;
    logic        pulse_b, busy_b, done_b, err_b;
    logic [15:0] rem_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_pulse_burst #(.HIGH_CYC(4), .LOW_CYC(4), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .count_in(count_in),
        .pulse_out(pulse_a), .busy(busy_a), .done(done_a),
        .remaining(rem_a), .err(err_a)
    );

    bcd_pulse_burst #(.HIGH_CYC(1), .LOW_CYC(1), .CW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start2), .count_in(count2),
        .pulse_out(pulse_b), .busy(busy_b), .done(done_b),
        .remaining(rem_b), .err(err_b)
    );

    function automatic logic [15:0] bin2bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic int bcd2bin(input logic [15:0] x);
        return int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic bit is_bcd(input logic [15:0] x);
        return (x[3:0] <= 4'd9) && (x[7:4] <= 4'd9) && (x[11:8] <= 4'd9) && (x[15:12] <= 4'd9);
    endfunction

    // Pulses whose high phase has finished by cycle t (cycle 1 = first after start).
    function automatic int pulses_finished(input int t, input int n, input int h, input int p);
        int c;
        if (t <= h) return 0;
        c = (t - h - 1) / p + 1;
        return (c > n) ? n : c;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Expected outputs of a burst of n pulses at cycle t after the accepted start.
    task automatic checkBurstCycle(input bit sel_b, input int t, input int n,
                                   input int h, input int l);
        int   p, total;
        logic ep, eb, ed;
        logic [15:0] er;
        p     = h + l;
        total = n * p;
        ep    = (t <= total) && (((t - 1) % p) < h);
        eb    = (t <= total);
        ed    = (t == total + 1);
        er    = bin2bcd(n - pulses_finished(t, n, h, p));
        if (!sel_b) begin
            checkBit("pulse_out", pulse_a, ep);
            checkBit("busy", busy_a, eb);
            checkBit("done", done_a, ed);
            checkOutput("remaining", rem_a, er);
            checkBit("err", err_a, 1'b0);
        end else begin
            checkBit("pulse_out_b", pulse_b, ep);
            checkBit("busy_b", busy_b, eb);
            checkBit("done_b", done_b, ed);
            checkOutput("remaining_b", rem_b, er);
        end
    endtask

    task automatic checkIdle(input string tag, input logic exp_err);
        checkBit({tag, "_pulse"}, pulse_a, 1'b0);
        checkBit({tag, "_busy"}, busy_a, 1'b0);
        checkBit({tag, "_done"}, done_a, 1'b0);
        checkOutput({tag, "_remaining"}, rem_a, 16'h0000);
        checkBit({tag, "_err"}, err_a, exp_err);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic applyStimulus(input logic [15:0] cnt, input bit poke);
        int   n, edges;
        logic prev;
        start    = 1'b1;
        count_in = cnt;
        @(negedge clk);
        start = 1'b0;
        if (!is_bcd(cnt)) begin
            for (int i = 0; i < 3; i++) begin
                checkIdle("invalid", 1'b1);
                @(negedge clk);
            end
            return;
        end
        n     = bcd2bin(cnt);
        edges = 0;
        prev  = 1'b0;
        for (int t = 1; t <= n * 8 + 1; t++) begin
            if (poke && t == 3) begin
                start    = 1'b1;
                count_in = bin2bcd(int'($urandom_range(1, 9999)));
            end else if (poke && t == 4) begin
                start    = 1'b0;
                count_in = cnt;
            end
            checkBurstCycle(1'b0, t, n, 4, 4);
            if (pulse_a === 1'b1 && prev !== 1'b1) edges++;
            prev = pulse_a;
            @(negedge clk);
        end
        checkIdle("after_done", 1'b0);
        checkOutput("rising_edges", 16'(edges), 16'(n));
        checkOutput("loopback", bin2bcd(edges), cnt);
    endtask

    initial begin
        logic [15:0] rc;
        $display("[TB] bcd_pulse_burst bench starting");
        rst      = 1'b1;
        start    = 1'b1;
        count_in = 16'h0005;
        start2   = 1'b0;
        count2   = 16'h0000;

        // Reset held with start asserted must not launch a burst.
        @(negedge clk);
        checkIdle("reset1", 1'b0);
        @(negedge clk);
        checkIdle("reset2", 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkIdle("post_reset", 1'b0);
        end

        $display("[TB] basic burst with overlapping start");
        applyStimulus(16'h0003, 1'b1);

        $display("[TB] borrow chain 1000 pulses");
        applyStimulus(16'h1000, 1'b0);

        $display("[TB] zero, invalid, recovery");
        applyStimulus(16'h0000, 1'b0);
        applyStimulus(16'h00A5, 1'b0);
        applyStimulus(16'h0001, 1'b0);

        $display("[TB] reset abort on second high cycle of pulse 2");
        start    = 1'b1;
        count_in = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            checkBurstCycle(1'b0, t, 3, 4, 4);
            if (t == 10) rst = 1'b1;
            @(negedge clk);
        end
        checkIdle("abort", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkIdle("abort_after", 1'b0);
        end

        $display("[TB] parameter corner HIGH_CYC=1 LOW_CYC=1");
        start2 = 1'b1;
        count2 = 16'h0002;
        @(negedge clk);
        start2 = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            checkBurstCycle(1'b1, t, 2, 1, 1);
            @(negedge clk);
        end

        $display("[TB] randomized bursts");
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rc      = bin2bcd(int'($urandom_range(0, 99)));
                rc[7:4] = 4'($urandom_range(10, 15));
                applyStimulus(rc, 1'b0);
            end else begin
                applyStimulus(bin2bcd(int'($urandom_range(0, 12))), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
